// File: rtl/bist_controller.sv
// BIST run sequencer: init pulse, fixed-length run window with periodic toggles,
// finish pulse, then a held completion flag until the next start request.
module bist_controller #(
  parameter int N_CYCLES      = 650,
  parameter int TOGGLE_PERIOD = 130
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic init,
  output logic running,
  output logic toggle,
  output logic finish,
  output logic bist_end
);

  localparam int CW = $clog2(N_CYCLES) + 1;
  localparam int PW = $clog2(TOGGLE_PERIOD) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(TOGGLE_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FINISH,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [PW-1:0]   phase;
  logic [PW-1:0]   phase_next;

  // phase tracks count mod TOGGLE_PERIOD so no divider is needed for the toggle test
  always_comb begin
    phase_next = (phase == LAST_PHASE) ? '0 : phase + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      phase    <= '0;
      init     <= 1'b0;
      running  <= 1'b0;
      toggle   <= 1'b0;
      finish   <= 1'b0;
      bist_end <= 1'b0;
    end else begin
      init   <= 1'b0;
      toggle <= 1'b0;
      finish <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= INIT;
            init     <= 1'b1;
            bist_end <= 1'b0;
          end
        end
        INIT: begin
          state   <= RUN;
          count   <= '0;
          phase   <= '0;
          running <= 1'b1;
          toggle  <= (LAST_PHASE == '0);
        end
        RUN: begin
          if (count == LAST_COUNT) begin
            state   <= FINISH;
            running <= 1'b0;
            finish  <= 1'b1;
          end else begin
            count  <= count + 1'b1;
            phase  <= phase_next;
            toggle <= (phase_next == LAST_PHASE);
          end
        end
        FINISH: begin
          state    <= DONE;
          bist_end <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          running  <= 1'b0;
          bist_end <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// Directed self-checking bench for bist_controller: default-sized instance for the
// run/restart/abort scenarios plus a small instance (10 cycles, period 3) for exact timing.
module tb_bist_controller;

  localparam int N   = 650;
  localparam int TP  = 130;
  localparam int N2  = 10;
  localparam int TP2 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic init, running, toggle, finish, bist_end;
  logic init2, running2, toggle2, finish2, bist_end2;
  logic [4:0] outs, outs2;

  int vectors = 0;
  int miscompares = 0;

  int runCnt = 0, togCnt = 0, finCnt = 0, initCnt = 0, exclErr = 0, lastTogErr = 0;
  int bRun, bTog, bFin, bInit, bExcl, bLast;
  logic prevToggle = 1'b0;

  assign outs  = {init, running, toggle, finish, bist_end};
  assign outs2 = {init2, running2, toggle2, finish2, bist_end2};

  bist_controller #(.N_CYCLES(N), .TOGGLE_PERIOD(TP)) dut (
    .clk(clk), .reset(reset), .start(start),
    .init(init), .running(running), .toggle(toggle),
    .finish(finish), .bist_end(bist_end)
  );

  bist_controller #(.N_CYCLES(N2), .TOGGLE_PERIOD(TP2)) dutSmall (
    .clk(clk), .reset(reset), .start(start2),
    .init(init2), .running(running2), .toggle(toggle2),
    .finish(finish2), .bist_end(bist_end2)
  );

  always #5 clk = ~clk;

  // Running tallies of the default instance, sampled mid-cycle on the falling edge
  always @(negedge clk) begin
    if (running)  runCnt  <= runCnt + 1;
    if (toggle)   togCnt  <= togCnt + 1;
    if (finish)   finCnt  <= finCnt + 1;
    if (init)     initCnt <= initCnt + 1;
    if ((int'(init) + int'(running) + int'(finish) + int'(bist_end)) > 1 || (toggle && !running))
      exclErr <= exclErr + 1;
    if (finish && !prevToggle)
      lastTogErr <= lastTogErr + 1;
    prevToggle <= toggle;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input int cycles);
    start = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic takeBase();
    #1;
    bRun = runCnt; bTog = togCnt; bFin = finCnt; bInit = initCnt;
    bExcl = exclErr; bLast = lastTogErr;
  endtask

  task automatic checkRun(input string tag, input int expRun, input int expTog,
                          input int expFin, input int expInit);
    #1;
    checkOutput({tag, ".runCycles"}, runCnt - bRun, expRun);
    checkOutput({tag, ".toggles"}, togCnt - bTog, expTog);
    checkOutput({tag, ".finishes"}, finCnt - bFin, expFin);
    checkOutput({tag, ".inits"}, initCnt - bInit, expInit);
    checkOutput({tag, ".exclusive"}, exclErr - bExcl, 0);
    checkOutput({tag, ".lastToggle"}, lastTogErr - bLast, 0);
  endtask

  initial begin
    logic [4:0] exp;

    $display("[TB] reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset.outs", outs, 5'b00000);
    checkOutput("reset.outsSmall", outs2, 5'b00000);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] normal run");
    takeBase();
    applyStimulus(1'b1, 1);
    checkOutput("t1.init", outs, 5'b10000);
    applyStimulus(1'b0, 1);
    checkOutput("t1.firstRun", outs, 5'b01000);
    repeat (N - 1) @(negedge clk);
    checkOutput("t1.lastRun", outs, 5'b01100);
    @(negedge clk);
    checkOutput("t1.finish", outs, 5'b00010);
    @(negedge clk);
    checkOutput("t1.bistEnd", outs, 5'b00001);
    repeat (5) @(negedge clk);
    checkRun("t1", N, N / TP, 1, 1);
    checkOutput("t1.held", outs, 5'b00001);

    $display("[TB] consecutive run");
    takeBase();
    applyStimulus(1'b1, 1);
    checkOutput("t2.restart", outs, 5'b10000);
    applyStimulus(1'b0, 700);
    checkRun("t2", N, N / TP, 1, 1);
    checkOutput("t2.held", outs, 5'b00001);

    $display("[TB] mid-run start");
    takeBase();
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 700);
    checkRun("t3", N, N / TP, 1, 1);

    $display("[TB] held start");
    takeBase();
    applyStimulus(1'b1, 6);
    applyStimulus(1'b0, 700);
    checkRun("t3b", N, N / TP, 1, 1);

    $display("[TB] start and reset overlap");
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 11);
    #1 reset = 1'b1;
    #1 checkOutput("t4.resetImmediate", outs, 5'b00000);
    @(negedge clk);
    applyStimulus(1'b1, 3);
    checkOutput("t4.startBlocked", outs, 5'b00000);
    takeBase();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t4.launch", outs, 5'b10000);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 700);
    checkRun("t4", N, N / TP, 1, 1);
    checkOutput("t4.held", outs, 5'b00001);

    $display("[TB] mid-run reset");
    takeBase();
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 5);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkRun("t5.abort", 5, 0, 0, 1);
    checkOutput("t5.idle", outs, 5'b00000);
    takeBase();
    applyStimulus(1'b1, 1);
    checkOutput("t5.init", outs, 5'b10000);
    applyStimulus(1'b0, 700);
    checkRun("t5", N, N / TP, 1, 1);
    checkOutput("t5.held", outs, 5'b00001);

    $display("[TB] small instance timing");
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkOutput("t6.init", outs2, 5'b10000);
    for (int k = 1; k <= N2; k++) begin
      @(negedge clk);
      exp = 5'b01000;
      exp[2] = (k % TP2 == 0);
      checkOutput($sformatf("t6.run%0d", k), outs2, exp);
    end
    @(negedge clk);
    checkOutput("t6.finish", outs2, 5'b00010);
    @(negedge clk);
    checkOutput("t6.bistEnd", outs2, 5'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
